// File: rtl/otter_pkg.sv
// Shared OTTER control types: FSM states, RV32I opcodes and SYSTEM funct3 codes.
// Imported by the control-unit sequencer and the combinational decoder.
package otter_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } cu_state_t;

  typedef enum logic [6:0] {
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    BRANCH = 7'b1100011,
    OP     = 7'b0110011,
    OP_IMM = 7'b0010011,
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    SYSTEM = 7'b1110011
  } opcode_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage

// File: rtl/cu_fsm_if.sv
// Control-unit bundle: IR fields and gated interrupt in, per-cycle strobes out.
// slave = sequencer side, master = datapath side.
interface cu_fsm_if;

  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       intr;
  logic       PCWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset_out;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  modport slave (
    input  ir6_0, ir14_12, intr,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset_out, csr_WE, int_taken, mret_exec
  );

  modport master (
    output ir6_0, ir14_12, intr,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset_out, csr_WE, int_taken, mret_exec
  );

endinterface

// File: rtl/cu_fsm.sv
// OTTER multi-cycle sequencer: 2 cycles per instruction, 3 for LOAD, +1 on trap entry.
// No backpressure; strobes are combinational from the registered state and IR fields.
module cu_fsm
  import otter_pkg::*;
#(
  parameter int INTR_EN     = 1,
  parameter int INIT_CYCLES = 1
) (
  input  logic     CLK,
  input  logic     RST,
  cu_fsm_if.slave  bus
);

  localparam int              CNT_W    = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  cu_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             irq_take;

  // Interrupts are only considered when an instruction retires.
  assign irq_take = (INTR_EN != 0) && bus.intr;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.PCWrite   = 1'b0;
    bus.regWrite  = 1'b0;
    bus.memWE2    = 1'b0;
    bus.memRDEN1  = 1'b0;
    bus.memRDEN2  = 1'b0;
    bus.reset_out = 1'b0;
    bus.csr_WE    = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;

    case (state)
      ST_INIT: begin
        bus.reset_out = 1'b1;
        // Counter stops at its last value, so it can never wrap.
        if (cnt == CNT_LAST) state_nxt = ST_FETCH;
        else                 cnt_nxt   = cnt + 1'b1;
      end

      ST_FETCH: begin
        bus.memRDEN1 = 1'b1;
        state_nxt    = ST_EXEC;
      end

      ST_EXEC: begin
        state_nxt = irq_take ? ST_INTR : ST_FETCH;
        case (opcode_t'(bus.ir6_0))
          LOAD: begin
            bus.memRDEN2 = 1'b1;
            state_nxt    = ST_WB;
          end
          STORE: begin
            bus.memWE2  = 1'b1;
            bus.PCWrite = 1'b1;
          end
          BRANCH: bus.PCWrite = 1'b1;
          OP, OP_IMM, LUI, AUIPC, JAL, JALR: begin
            bus.regWrite = 1'b1;
            bus.PCWrite  = 1'b1;
          end
          SYSTEM: begin
            bus.PCWrite = 1'b1;
            if (bus.ir14_12 == F3_MRET) begin
              bus.mret_exec = 1'b1;
            end else if (bus.ir14_12 == F3_CSRRW) begin
              bus.csr_WE   = 1'b1;
              bus.regWrite = 1'b1;
            end
          end
          default: bus.PCWrite = 1'b1;
        endcase
      end

      ST_WB: begin
        bus.regWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        state_nxt    = irq_take ? ST_INTR : ST_FETCH;
      end

      ST_INTR: begin
        bus.int_taken = 1'b1;
        bus.PCWrite   = 1'b1;
        state_nxt     = ST_FETCH;
      end

      default: state_nxt = ST_INIT;
    endcase
  end

endmodule
